// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states and
// the alignment/legality check applied when a request is accepted.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } lsuSize_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_READ,
        STORE,
        RESP
    } lsuState_e;

    // A request is rejected for an illegal size or a misaligned half/word.
    function automatic logic isAccessError(input logic [1:0] size, input logic [1:0] offset);
        logic err;
        err = 1'b0;
        case (lsuSize_e'(size))
            SIZE_ILLEGAL: err = 1'b1;
            SIZE_HALF:    err = offset[0];
            SIZE_WORD:    err = (offset != 2'b00);
            default:      err = 1'b0;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Big-endian lane handling: extracts and extends a loaded byte/half, and merges
// store data into a previously read word for read-modify-write stores.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] rawWord,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        signExtend,
    input  logic [15:0] storeData,
    output logic [31:0] loadData,
    output logic [31:0] mergedWord
);

    logic [7:0]  laneByte;
    logic [15:0] laneHalf;

    // Byte offset 0 is the most significant byte of the word.
    always_comb begin
        laneByte = rawWord[31:24];
        case (offset)
            2'd0: laneByte = rawWord[31:24];
            2'd1: laneByte = rawWord[23:16];
            2'd2: laneByte = rawWord[15:8];
            2'd3: laneByte = rawWord[7:0];
            default: laneByte = rawWord[31:24];
        endcase
        laneHalf = offset[1] ? rawWord[15:0] : rawWord[31:16];

        loadData = rawWord;
        case (lsuSize_e'(size))
            SIZE_BYTE: loadData = {{24{signExtend & laneByte[7]}}, laneByte};
            SIZE_HALF: loadData = {{16{signExtend & laneHalf[15]}}, laneHalf};
            default:   loadData = rawWord;
        endcase
    end

    always_comb begin
        mergedWord = rawWord;
        case (lsuSize_e'(size))
            SIZE_BYTE: begin
                case (offset)
                    2'd0: mergedWord[31:24] = storeData[7:0];
                    2'd1: mergedWord[23:16] = storeData[7:0];
                    2'd2: mergedWord[15:8]  = storeData[7:0];
                    2'd3: mergedWord[7:0]   = storeData[7:0];
                    default: mergedWord = rawWord;
                endcase
            end
            SIZE_HALF: begin
                if (offset[1]) mergedWord[15:0]  = storeData;
                else           mergedWord[31:16] = storeData;
            end
            default: mergedWord = rawWord;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a combinational-read,
// big-endian word memory; sub-word stores go through a read-modify-write.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    lsuState_e   state;
    logic [1:0]  offsetReg;
    logic [1:0]  sizeReg;
    logic        signedReg;
    logic [15:0] wdataReg;
    logic [31:0] loadData;
    logic [31:0] mergedWord;

    lsu_byte_lane laneUnit (
        .rawWord    (mem_rdata),
        .offset     (offsetReg),
        .size       (sizeReg),
        .signExtend (signedReg),
        .storeData  (wdataReg),
        .loadData   (loadData),
        .mergedWord (mergedWord)
    );

    // All handshake and memory outputs are registered; each memory strobe is
    // raised on entry to its state and dropped on the edge that leaves it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            offsetReg <= '0;
            sizeReg   <= '0;
            signedReg <= 1'b0;
            wdataReg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        offsetReg <= req_addr[1:0];
                        sizeReg   <= req_size;
                        signedReg <= req_signed;
                        wdataReg  <= req_wdata[15:0];
                        rsp_rdata <= '0;
                        req_ready <= 1'b0;
                        if (isAccessError(req_size, req_addr[1:0])) begin
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            rsp_err  <= 1'b0;
                            mem_addr <= {req_addr[31:2], 2'b00};
                            if (!req_we) begin
                                mem_read <= 1'b1;
                                state    <= LOAD;
                            end else if (lsuSize_e'(req_size) == SIZE_WORD) begin
                                mem_wdata <= req_wdata;
                                mem_write <= 1'b1;
                                state     <= STORE;
                            end else begin
                                mem_read <= 1'b1;
                                state    <= RMW_READ;
                            end
                        end
                    end
                end
                LOAD: begin
                    mem_read  <= 1'b0;
                    rsp_rdata <= loadData;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RMW_READ: begin
                    mem_read  <= 1'b0;
                    mem_wdata <= mergedWord;
                    mem_write <= 1'b1;
                    state     <= STORE;
                end
                STORE: begin
                    mem_write <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a behavioural
// big-endian word memory and a strobe monitor.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];

    int checks = 0;
    int failures = 0;

    int          readCount = 0;
    int          writeCount = 0;
    int          bothCount = 0;
    logic [31:0] lastReadAddr = '0;
    logic [31:0] lastWriteAddr = '0;
    logic [31:0] lastWriteData = '0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_signed(req_signed),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[7:2]];

    // Memory commits and strobe bookkeeping on each rising edge.
    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[7:2]] <= mem_wdata;
            writeCount    <= writeCount + 1;
            lastWriteAddr <= mem_addr;
            lastWriteData <= mem_wdata;
        end
        if (mem_read) begin
            readCount    <= readCount + 1;
            lastReadAddr <= mem_addr;
        end
        if (mem_read && mem_write) bothCount <= bothCount + 1;
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
        int          expLat;
        int          expReads;
        int          expWrites;
        logic [31:0] expWdata;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int holdCycles, input string name);
        int lat;
        int readsBefore;
        int writesBefore;
        @(negedge clk);
        checkOutput({name, " req_ready idle"}, 32'(req_ready), 32'd1);
        readsBefore  = readCount;
        writesBefore = writeCount;
        req_valid  = 1'b1;
        req_we     = v.we;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        rsp_ready  = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        checkOutput({name, " latency"}, 32'(lat), 32'(v.expLat));
        checkOutput({name, " rdata"}, rsp_rdata, v.expRdata);
        checkOutput({name, " err"}, 32'(rsp_err), 32'(v.expErr));
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            checkOutput($sformatf("%s hold%0d rsp_valid", name, i), 32'(rsp_valid), 32'd1);
            checkOutput($sformatf("%s hold%0d req_ready", name, i), 32'(req_ready), 32'd0);
            checkOutput($sformatf("%s hold%0d rdata", name, i), rsp_rdata, v.expRdata);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput({name, " back to idle"}, 32'(req_ready), 32'd1);
        checkOutput({name, " rsp_valid dropped"}, 32'(rsp_valid), 32'd0);
        checkOutput({name, " reads"}, 32'(readCount - readsBefore), 32'(v.expReads));
        checkOutput({name, " writes"}, 32'(writeCount - writesBefore), 32'(v.expWrites));
        if (v.expReads > 0)
            checkOutput({name, " read addr"}, lastReadAddr, {v.addr[31:2], 2'b00});
        if (v.expWrites > 0) begin
            checkOutput({name, " write addr"}, lastWriteAddr, {v.addr[31:2], 2'b00});
            checkOutput({name, " write data"}, lastWriteData, v.expWdata);
        end
    endtask

    vec_t vecs[13];
    vec_t wordStore;
    vec_t reloadStore;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[32'h14 >> 2] = 32'h55555555;
        mem[32'h28 >> 2] = 32'hAAAAAAAA;

        //                 we    size   sgn   addr        wdata         expRdata      err  lat rd wr expWdata
        vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h14, 32'h0,        32'h55555555, 1'b0, 2, 1, 0, 32'h0};
        vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h29, 32'h0,        32'hFFFFFFAA, 1'b0, 2, 1, 0, 32'h0};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h29, 32'h0,        32'h000000AA, 1'b0, 2, 1, 0, 32'h0};
        vecs[3]  = '{1'b0, 2'b01, 1'b1, 32'h2A, 32'h0,        32'hFFFFAAAA, 1'b0, 2, 1, 0, 32'h0};
        vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h28, 32'h0,        32'h0000AAAA, 1'b0, 2, 1, 0, 32'h0};
        vecs[5]  = '{1'b1, 2'b00, 1'b0, 32'h15, 32'hFFFFFF99, 32'h0,        1'b0, 3, 1, 1, 32'h55995555};
        vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h14, 32'h0,        32'h55995555, 1'b0, 2, 1, 0, 32'h0};
        vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'h15, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
        vecs[8]  = '{1'b0, 2'b11, 1'b0, 32'h14, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
        vecs[9]  = '{1'b1, 2'b10, 1'b0, 32'h16, 32'h12345678, 32'h0,        1'b1, 1, 0, 0, 32'h0};
        vecs[10] = '{1'b1, 2'b01, 1'b0, 32'h16, 32'hABCD1234, 32'h0,        1'b0, 3, 1, 1, 32'h55991234};
        vecs[11] = '{1'b0, 2'b00, 1'b1, 32'h17, 32'h0,        32'h00000034, 1'b0, 2, 1, 0, 32'h0};
        vecs[12] = '{1'b0, 2'b00, 1'b1, 32'h14, 32'h0,        32'h00000055, 1'b0, 2, 1, 0, 32'h0};
        wordStore   = '{1'b1, 2'b10, 1'b0, 32'h28, 32'hEEEEEEEE, 32'h0,        1'b0, 2, 0, 1, 32'hEEEEEEEE};
        reloadStore = '{1'b0, 2'b10, 1'b0, 32'h28, 32'h0,        32'hEEEEEEEE, 1'b0, 2, 1, 0, 32'h0};

        rst = 1'b1;
        #12;
        checkOutput("reset req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset mem_addr", mem_addr, 32'h0);
        checkOutput("reset strobes", {30'd0, mem_read, mem_write}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a read-modify-write must not touch memory.
        begin
            int writesBefore;
            writesBefore = writeCount;
            @(negedge clk);
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_size  = 2'b00;
            req_addr  = 32'h14;
            req_wdata = 32'h000000CC;
            @(posedge clk);
            #1 req_valid = 1'b0;
            @(negedge clk);
            checkOutput("rmw mem_read before reset", 32'(mem_read), 32'd1);
            rst = 1'b1;
            #1;
            checkOutput("midreset req_ready", 32'(req_ready), 32'd1);
            checkOutput("midreset rsp_valid", 32'(rsp_valid), 32'd0);
            checkOutput("midreset rsp_rdata", rsp_rdata, 32'h0);
            checkOutput("midreset rsp_err", 32'(rsp_err), 32'd0);
            checkOutput("midreset strobes", {30'd0, mem_read, mem_write}, 32'd0);
            checkOutput("midreset mem_addr", mem_addr, 32'h0);
            checkOutput("midreset mem_wdata", mem_wdata, 32'h0);
            repeat (2) @(negedge clk);
            rst = 1'b0;
            repeat (3) begin
                @(negedge clk);
                checkOutput("post reset no response", 32'(rsp_valid), 32'd0);
            end
            checkOutput("post reset writes", 32'(writeCount - writesBefore), 32'd0);
            checkOutput("post reset mem 0x14", mem[32'h14 >> 2], 32'h55555555);
        end

        for (int i = 0; i < 13; i++)
            applyStimulus(vecs[i], 0, $sformatf("vec%0d", i));

        applyStimulus(wordStore, 3, "word store stall");
        applyStimulus(reloadStore, 0, "reload 0x28");

        checkOutput("read/write overlap", 32'(bothCount), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
